// File: rtl/cpu_pkg.sv
// Shared register-file types for the write-back path.
// Widths here size the FIFO entry storage.
package cpu_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over pending write-back entries.
// Entries are scanned oldest to newest so the last hit wins.
module wb_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                      [PTR_W-1:0]  rd_ptr,
    input  logic                      [DEPTH-1:0]  valid,
    input  cpu_pkg::wb_entry_t        [DEPTH-1:0]  entries,
    input  logic                      [ADDR_W-1:0] addr,
    output logic                                   hit,
    output logic                      [DATA_W-1:0] data
);
    import cpu_pkg::*;

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (valid[idx] && entries[idx].dest == addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback_buffer.sv
// In-order write-back FIFO feeding the register file write port,
// with forwarding of pending writes to both read ports.
module reg_writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Alu_Valid,
    input  logic [ADDR_W-1:0] Alu_Reg,
    input  logic [DATA_W-1:0] Alu_Data,
    input  logic              Mem_Valid,
    input  logic [ADDR_W-1:0] Mem_Reg,
    input  logic [DATA_W-1:0] Mem_Data,
    output logic              Stall,
    output logic [ADDR_W-1:0] Write_Reg,
    output logic [DATA_W-1:0] Write_Data,
    output logic              RegWrite,
    input  logic [ADDR_W-1:0] Read_Reg_Add1,
    input  logic [ADDR_W-1:0] Read_Reg_Add2,
    output logic              Fwd_Hit1,
    output logic [DATA_W-1:0] Fwd_Data1,
    output logic              Fwd_Hit2,
    output logic [DATA_W-1:0] Fwd_Data2
);
    import cpu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic      [PTR_W-1:0] rd_ptr;
    logic      [PTR_W-1:0] wr_ptr;
    logic      [PTR_W-1:0] alu_slot;
    logic      [CNT_W-1:0] count;
    logic      [CNT_W-1:0] count_next;
    logic      [CNT_W-1:0] free;
    logic      [DEPTH-1:0] valid;
    logic      [DEPTH-1:0] valid_next;
    wb_entry_t [DEPTH-1:0] entries;
    logic                  push_mem;
    logic                  push_alu;
    logic                  pop;
    logic      [1:0]       n_push;

    // Two slots stay in reserve so a dual push can never overflow.
    assign free  = CNT_W'(DEPTH) - count;
    assign Stall = free < CNT_W'(2);

    assign push_mem = Mem_Valid && !Stall;
    assign push_alu = Alu_Valid && !Stall;
    assign n_push   = {1'b0, push_mem} + {1'b0, push_alu};
    assign pop      = count != '0;

    // Mem is the older instruction, so it takes the first free slot.
    assign alu_slot = wr_ptr + PTR_W'(push_mem);

    assign count_next = count + CNT_W'(n_push) - CNT_W'(pop);

    always_comb begin
        valid_next = valid;
        if (pop) begin
            valid_next[rd_ptr] = 1'b0;
        end
        if (push_mem) begin
            valid_next[wr_ptr] = 1'b1;
        end
        if (push_alu) begin
            valid_next[alu_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            count  <= count_next;
            valid  <= valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_mem) begin
            entries[wr_ptr] <= '{dest: Mem_Reg, data: Mem_Data};
        end
        if (!reset && push_alu) begin
            entries[alu_slot] <= '{dest: Alu_Reg, data: Alu_Data};
        end
    end

    assign RegWrite   = pop;
    assign Write_Reg  = pop ? entries[rd_ptr].dest : '0;
    assign Write_Data = pop ? entries[rd_ptr].data : '0;

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd1 (
        .rd_ptr  (rd_ptr),
        .valid   (valid),
        .entries (entries),
        .addr    (Read_Reg_Add1),
        .hit     (Fwd_Hit1),
        .data    (Fwd_Data1)
    );

    wb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd2 (
        .rd_ptr  (rd_ptr),
        .valid   (valid),
        .entries (entries),
        .addr    (Read_Reg_Add2),
        .hit     (Fwd_Hit2),
        .data    (Fwd_Data2)
    );

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Directed vectors plus a streaming sequence for reg_writeback_buffer.
module tb_reg_writeback_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Alu_Valid;
    logic [3:0]  Alu_Reg;
    logic [15:0] Alu_Data;
    logic        Mem_Valid;
    logic [3:0]  Mem_Reg;
    logic [15:0] Mem_Data;
    logic        Stall;
    logic [3:0]  Write_Reg;
    logic [15:0] Write_Data;
    logic        RegWrite;
    logic [3:0]  Read_Reg_Add1;
    logic [3:0]  Read_Reg_Add2;
    logic        Fwd_Hit1;
    logic [15:0] Fwd_Data1;
    logic        Fwd_Hit2;
    logic [15:0] Fwd_Data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_writeback_buffer #(.DEPTH(4), .ADDR_W(4), .DATA_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .Alu_Valid     (Alu_Valid),
        .Alu_Reg       (Alu_Reg),
        .Alu_Data      (Alu_Data),
        .Mem_Valid     (Mem_Valid),
        .Mem_Reg       (Mem_Reg),
        .Mem_Data      (Mem_Data),
        .Stall         (Stall),
        .Write_Reg     (Write_Reg),
        .Write_Data    (Write_Data),
        .RegWrite      (RegWrite),
        .Read_Reg_Add1 (Read_Reg_Add1),
        .Read_Reg_Add2 (Read_Reg_Add2),
        .Fwd_Hit1      (Fwd_Hit1),
        .Fwd_Data1     (Fwd_Data1),
        .Fwd_Hit2      (Fwd_Hit2),
        .Fwd_Data2     (Fwd_Data2)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [3:0]  ar;
        logic [15:0] ad;
        logic        mv;
        logic [3:0]  mr;
        logic [15:0] md;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic        e_we;
        logic [3:0]  e_wr;
        logic [15:0] e_wd;
        logic        e_st;
        logic        e_h1;
        logic [15:0] e_d1;
        logic        e_h2;
        logic [15:0] e_d2;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(
        int rst, int av, int ar, int ad, int mv, int mr, int md,
        int r1, int r2, int we, int wr, int wd, int st,
        int h1, int d1, int h2, int d2);
        vec_t v;
        v.rst  = rst[0];
        v.av   = av[0];
        v.ar   = ar[3:0];
        v.ad   = ad[15:0];
        v.mv   = mv[0];
        v.mr   = mr[3:0];
        v.md   = md[15:0];
        v.r1   = r1[3:0];
        v.r2   = r2[3:0];
        v.e_we = we[0];
        v.e_wr = wr[3:0];
        v.e_wd = wd[15:0];
        v.e_st = st[0];
        v.e_h1 = h1[0];
        v.e_d1 = d1[15:0];
        v.e_h2 = h2[0];
        v.e_d2 = d2[15:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    logic [19:0] q[$];
    int          cnt_m;
    int          seq;
    int          cyc;
    int          writes;
    int          accepted;
    logic        acc;

    initial begin
        reset     = 1'b1;
        Alu_Valid = 1'b0;
        Alu_Reg   = '0;
        Alu_Data  = '0;
        Mem_Valid = 1'b0;
        Mem_Reg   = '0;
        Mem_Data  = '0;
        Read_Reg_Add1 = '0;
        Read_Reg_Add2 = '0;

        //            rst av ar ad       mv mr md       r1 r2  we wr wd       st h1 d1       h2 d2
        vecs[0]  = mk(1, 0, 0, 0,       0, 0, 0,       0, 0,  0, 0, 0,       0, 0, 0,       0, 0);
        vecs[1]  = mk(0, 0, 0, 0,       0, 0, 0,       2, 0,  0, 0, 0,       0, 0, 0,       0, 0);
        vecs[2]  = mk(0, 0, 0, 0,       0, 0, 0,       2, 0,  0, 0, 0,       0, 0, 0,       0, 0);
        vecs[3]  = mk(0, 1, 2, 'h1234,  0, 0, 0,       2, 0,  1, 2, 'h1234,  0, 1, 'h1234,  0, 0);
        vecs[4]  = mk(0, 0, 0, 0,       0, 0, 0,       2, 0,  0, 0, 0,       0, 0, 0,       0, 0);
        vecs[5]  = mk(0, 1, 4, 'h9ABC,  1, 3, 'h5678,  3, 4,  1, 3, 'h5678,  0, 1, 'h5678,  1, 'h9ABC);
        vecs[6]  = mk(0, 0, 0, 0,       0, 0, 0,       3, 4,  1, 4, 'h9ABC,  0, 0, 0,       1, 'h9ABC);
        vecs[7]  = mk(0, 0, 0, 0,       0, 0, 0,       3, 4,  0, 0, 0,       0, 0, 0,       0, 0);
        vecs[8]  = mk(0, 1, 5, 'h2222,  1, 5, 'h1111,  5, 0,  1, 5, 'h1111,  0, 1, 'h2222,  0, 0);
        vecs[9]  = mk(0, 0, 0, 0,       0, 0, 0,       5, 0,  1, 5, 'h2222,  0, 1, 'h2222,  0, 0);
        vecs[10] = mk(0, 0, 0, 0,       0, 0, 0,       5, 0,  0, 0, 0,       0, 0, 0,       0, 0);
        vecs[11] = mk(0, 1, 1, 'h0001,  1, 0, 'hBEEF,  0, 1,  1, 0, 'hBEEF,  0, 1, 'hBEEF,  1, 'h0001);
        vecs[12] = mk(0, 1, 7, 'hBBBB,  1, 6, 'hAAAA,  0, 7,  1, 1, 'h0001,  1, 0, 0,       1, 'hBBBB);
        vecs[13] = mk(0, 1, 9, 'hDDDD,  1, 8, 'hCCCC,  6, 8,  1, 6, 'hAAAA,  0, 1, 'hAAAA,  0, 0);
        vecs[14] = mk(0, 1, 9, 'hDDDD,  1, 8, 'hCCCC,  6, 8,  1, 7, 'hBBBB,  1, 0, 0,       1, 'hCCCC);
        vecs[15] = mk(0, 0, 0, 0,       0, 0, 0,       9, 7,  1, 8, 'hCCCC,  0, 1, 'hDDDD,  0, 0);
        vecs[16] = mk(0, 1, 11, 'h0002, 1, 10, 'h0001, 11, 10, 1, 9, 'hDDDD, 1, 1, 'h0002,  1, 'h0001);
        vecs[17] = mk(1, 1, 12, 'h3333, 0, 0, 0,       11, 10, 0, 0, 0,      0, 0, 0,       0, 0);
        vecs[18] = mk(0, 0, 0, 0,       0, 0, 0,       11, 10, 0, 0, 0,      0, 0, 0,       0, 0);
        vecs[19] = mk(0, 0, 0, 0,       0, 0, 0,       12, 0,  0, 0, 0,      0, 0, 0,       0, 0);

        for (int i = 0; i < NV; i++) begin
            reset         = vecs[i].rst;
            Alu_Valid     = vecs[i].av;
            Alu_Reg       = vecs[i].ar;
            Alu_Data      = vecs[i].ad;
            Mem_Valid     = vecs[i].mv;
            Mem_Reg       = vecs[i].mr;
            Mem_Data      = vecs[i].md;
            Read_Reg_Add1 = vecs[i].r1;
            Read_Reg_Add2 = vecs[i].r2;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d RegWrite", i),   32'(RegWrite),   32'(vecs[i].e_we));
            chk($sformatf("v%0d Write_Reg", i),  32'(Write_Reg),  32'(vecs[i].e_wr));
            chk($sformatf("v%0d Write_Data", i), 32'(Write_Data), 32'(vecs[i].e_wd));
            chk($sformatf("v%0d Stall", i),      32'(Stall),      32'(vecs[i].e_st));
            chk($sformatf("v%0d Fwd_Hit1", i),   32'(Fwd_Hit1),   32'(vecs[i].e_h1));
            chk($sformatf("v%0d Fwd_Data1", i),  32'(Fwd_Data1),  32'(vecs[i].e_d1));
            chk($sformatf("v%0d Fwd_Hit2", i),   32'(Fwd_Hit2),   32'(vecs[i].e_h2));
            chk($sformatf("v%0d Fwd_Data2", i),  32'(Fwd_Data2),  32'(vecs[i].e_d2));
        end

        // Streaming dual pushes held through stalls, many pointer laps.
        reset    = 1'b0;
        cnt_m    = 0;
        seq      = 0;
        cyc      = 0;
        writes   = 0;
        accepted = 0;
        while ((seq < 24 || cnt_m != 0) && cyc < 300) begin
            Mem_Valid = seq < 24;
            Alu_Valid = seq < 24;
            Mem_Reg   = 4'(seq);
            Mem_Data  = 16'h4000 | 16'(seq);
            Alu_Reg   = 4'(seq + 1);
            Alu_Data  = 16'h8000 | 16'(seq);
            acc = (seq < 24) && ((4 - cnt_m) >= 2);
            @(posedge clk);
            if (cnt_m != 0) begin
                void'(q.pop_front());
                cnt_m--;
            end
            if (acc) begin
                q.push_back({Mem_Reg, Mem_Data});
                q.push_back({Alu_Reg, Alu_Data});
                cnt_m    += 2;
                accepted += 2;
                seq++;
            end
            #1;
            cyc++;
            chk("s Stall", 32'(Stall), 32'((4 - cnt_m) < 2));
            chk("s RegWrite", 32'(RegWrite), 32'(cnt_m != 0));
            if (RegWrite) begin
                writes++;
            end
            if (cnt_m != 0) begin
                chk("s Write_Reg", 32'(Write_Reg), 32'(q[0][19:16]));
                chk("s Write_Data", 32'(Write_Data), 32'(q[0][15:0]));
            end
        end
        chk("s drained", 32'(cyc < 300), 32'(1));
        chk("s writes", 32'(writes), 32'(accepted));
        chk("s accepted", 32'(accepted), 32'(48));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
